bcd_updown_scan_counter: RTL
============================

Name: bcd_updown_scan_counter

Overview:
Parameterised multi-digit BCD up/down counter with an integrated time-multiplexed 7-segment display driver.
- Single clock domain; counting uses a one-cycle clock-enable tick, never a derived clock.
- Supports hold, up, down and parallel load, with a wrap pulse for cascading.
- Sits between board switches and the on-board common-anode 7-segment display.

Parameters:
- NUM_DIGITS, 4: number of BCD digits counted and displayed (1..8).
- TICK_DIV, 100_000_000: clk cycles per count tick (1 s at 100 MHz); must be >= 2.
- REFRESH_DIV, 100_000: clk cycles each digit stays enabled during scan; must be >= 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- en  in  1  count enable; gates up/down only.
- sel  in  2  mode: 00 hold, 01 up, 10 down, 11 load.
- load_val  in  4*NUM_DIGITS  BCD load value; digit k is bits [4k+3:4k].
- count  out  4*NUM_DIGITS  current BCD count, registered.
- tick  out  1  one-cycle count-tick strobe.
- wrap  out  1  one-cycle pulse on a counting wrap.
- seg  out  7  {a,b,c,d,e,f,g}, active-low.
- an  out  NUM_DIGITS  digit enables, active-low, one-hot-low.

Behaviour:
Reset (rst=1 at a rising edge) dominates everything. It clears:
- count=0, tick=0, wrap=0;
- internal tick counter and refresh counter to 0, scan index to 0;
- seg=7'b1111111 (blank), an=all ones.

Tick generator:
- Counter runs 0..TICK_DIV-1 continuously, independent of en and sel.
- tick=1 for exactly the cycle in which the counter equals TICK_DIV-1.
- First tick after reset release occurs TICK_DIV cycles later.

Count update (registered; count changes the cycle after the qualifying edge):
- sel=11: count <= load_val on the next edge regardless of tick and en. Any load digit >9 is coerced to 0. wrap=0.
- sel=01, en=1, tick=1: BCD increment. Digit 9 -> 0 and carry into the next digit. All-nines -> all-zero with wrap=1 for one cycle.
- sel=10, en=1, tick=1: BCD decrement. Digit 0 -> 9 and borrow from the next digit. All-zero -> all-nines with wrap=1 for one cycle.
- sel=00, en=0, or tick=0: count holds, wrap=0.
- sel is sampled only in the cycle it acts; a change mid-period takes effect at the next tick.
- Digits never hold values >9 in any reachable state.

Display scan:
- Refresh counter runs 0..REFRESH_DIV-1.
- On wrap of the refresh counter, scan index advances 0..NUM_DIGITS-1 cyclically.
- Each cycle, an and seg are registered from the current index and count:
  - an[idx]=0, all other an bits = 1;
  - seg = decode of digit idx.
- Latency: one cycle from any count or index change to seg/an.
- Decode table (seg order a..g):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
  - Unreachable values: 1111110.

Test Plan:
All tests use NUM_DIGITS=2, TICK_DIV=4, REFRESH_DIV=2.
1. Reset: rst=1 for 3 cycles mid-operation -> count=8'h00, tick=0, wrap=0, an=2'b11, seg=7'b1111111. After release, first tick on the 4th cycle; an=2'b10, seg=0000001 one cycle after release.
2. Up wrap: sel=01, en=1, 100 ticks from 0 -> count 8'h09 -> 8'h10 (BCD carry). 8'h99 -> 8'h00 with wrap=1 for exactly one cycle; no other wrap pulses.
3. Down wrap: sel=10, en=1 from 8'h10 -> 8'h09. Continue to 8'h00, then 8'h99 with wrap=1 for one cycle.
4. Load: load_val=8'h3A, sel=11 in a non-tick cycle -> count=8'h30 next cycle, wrap=0. sel=11 held across a tick -> count stays 8'h30.
5. Scan: count=8'h47 held -> an alternates 2'b10 (seg=0001111) and 2'b01 (seg=1001100), each for 2 cycles.
6. Hold/enable: sel=00, or sel=01 with en=0, across 5 ticks -> count unchanged, wrap=0, tick still pulses every 4 cycles. Re-enabling counts on the next tick.

Source files
------------

// File: rtl/bcd_updown_scan_counter_if.sv
// Switch-side controls and display-side outputs of the BCD up/down scan counter.
interface bcd_updown_scan_counter_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  logic                    en;
  logic [1:0]              sel;
  logic [4*NUM_DIGITS-1:0] load_val;
  logic [4*NUM_DIGITS-1:0] count;
  logic                    tick;
  logic                    wrap;
  logic [6:0]              seg;
  logic [NUM_DIGITS-1:0]   an;

  modport master (
    output en, sel, load_val,
    input  count, tick, wrap, seg, an
  );

  modport slave (
    input  en, sel, load_val,
    output count, tick, wrap, seg, an
  );
endinterface

// File: rtl/bcd_updown_scan_counter.sv
// Multi-digit BCD up/down/load counter with a tick-enable generator and a
// time-multiplexed common-anode 7-segment scan driver.
module bcd_updown_scan_counter #(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned TICK_DIV    = 100_000_000,
  parameter int unsigned REFRESH_DIV = 100_000
) (
  input logic                         clk,
  input logic                         rst,
  bcd_updown_scan_counter_if.slave    bus
);

  localparam int unsigned TW = $clog2(TICK_DIV);
  localparam int unsigned RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned CW = 4 * NUM_DIGITS;

  typedef enum logic [1:0] {
    SelHold = 2'b00,
    SelUp   = 2'b01,
    SelDown = 2'b10,
    SelLoad = 2'b11
  } sel_e;

  logic [TW-1:0]         tick_cnt_q, tick_cnt_d;
  logic [RW-1:0]         refresh_cnt_q, refresh_cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  wrap_q, wrap_d;
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;

  logic          tick;
  logic          refresh_wrap;
  logic [CW-1:0] inc_val, dec_val, load_fix;
  logic          inc_carry, dec_borrow;
  logic [3:0]    cur_digit;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = 7'b1111110;
    endcase
    return s;
  endfunction

  // Free-running tick divider, independent of en/sel.
  assign tick       = (tick_cnt_q == TW'(TICK_DIV - 1));
  assign tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);

  assign refresh_wrap  = (refresh_cnt_q == RW'(REFRESH_DIV - 1));
  assign refresh_cnt_d = refresh_wrap ? '0 : refresh_cnt_q + RW'(1);

  always_comb begin
    idx_d = idx_q;
    if (refresh_wrap) begin
      idx_d = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + IW'(1);
    end
  end

  // Ripple BCD increment/decrement; a carry/borrow out of the top digit is the wrap.
  always_comb begin
    inc_val    = count_q;
    dec_val    = count_q;
    load_fix   = '0;
    inc_carry  = 1'b1;
    dec_borrow = 1'b1;
    for (int k = 0; k < int'(NUM_DIGITS); k++) begin
      if (inc_carry) begin
        if (count_q[4*k +: 4] == 4'd9) begin
          inc_val[4*k +: 4] = 4'd0;
        end else begin
          inc_val[4*k +: 4] = count_q[4*k +: 4] + 4'd1;
          inc_carry         = 1'b0;
        end
      end
      if (dec_borrow) begin
        if (count_q[4*k +: 4] == 4'd0) begin
          dec_val[4*k +: 4] = 4'd9;
        end else begin
          dec_val[4*k +: 4] = count_q[4*k +: 4] - 4'd1;
          dec_borrow        = 1'b0;
        end
      end
      load_fix[4*k +: 4] = (bus.load_val[4*k +: 4] > 4'd9) ? 4'd0 : bus.load_val[4*k +: 4];
    end
  end

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    unique case (sel_e'(bus.sel))
      SelHold: ;
      SelUp: begin
        if (bus.en && tick) begin
          count_d = inc_val;
          wrap_d  = inc_carry;
        end
      end
      SelDown: begin
        if (bus.en && tick) begin
          count_d = dec_val;
          wrap_d  = dec_borrow;
        end
      end
      SelLoad: count_d = load_fix;
    endcase
  end

  always_comb begin
    cur_digit = 4'd0;
    an_d      = '1;
    for (int k = 0; k < int'(NUM_DIGITS); k++) begin
      if (idx_q == IW'(k)) begin
        cur_digit = count_q[4*k +: 4];
        an_d[k]   = 1'b0;
      end
    end
    seg_d = seg_decode(cur_digit);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_q    <= '0;
      refresh_cnt_q <= '0;
      idx_q         <= '0;
      count_q       <= '0;
      wrap_q        <= 1'b0;
      seg_q         <= 7'b1111111;
      an_q          <= '1;
    end else begin
      tick_cnt_q    <= tick_cnt_d;
      refresh_cnt_q <= refresh_cnt_d;
      idx_q         <= idx_d;
      count_q       <= count_d;
      wrap_q        <= wrap_d;
      seg_q         <= seg_d;
      an_q          <= an_d;
    end
  end

  assign bus.count = count_q;
  assign bus.tick  = tick;
  assign bus.wrap  = wrap_q;
  assign bus.seg   = seg_q;
  assign bus.an    = an_q;

endmodule
